// File: rtl/modulation_params_pkg.sv
// Shared widths, types and helpers for the modulation read path.
package modulation_params_pkg;

    localparam int DEPTH_BITS   = 15;
    localparam int READ_LATENCY = 2;
    localparam int DIV_BITS     = 16;
    localparam int REP_BITS     = 16;

    typedef logic [DEPTH_BITS-1:0] mod_idx_t;
    typedef logic [DIV_BITS-1:0]   div_t;
    typedef logic [REP_BITS-1:0]   rep_t;

    localparam rep_t REPEAT_INFINITE = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FINISHED
    } state_t;

    // Tag travelling alongside each BRAM fetch.
    typedef struct packed {
        logic     valid;
        mod_idx_t idx;
        logic     page;
    } fetch_tag_t;

    // Terminal divider count; a divider of 0 behaves as 1.
    function automatic div_t div_last(input div_t freq_div);
        return (freq_div == '0) ? '0 : freq_div - div_t'(1);
    endfunction

endpackage

// File: rtl/modulation_sampler_if.sv
// Read port of the modulation BRAM: address/page out, byte back.
interface modulation_sampler_if;
    import modulation_params_pkg::*;

    mod_idx_t   ADDR;
    logic       PAGE;
    logic [7:0] VALUE;

    modport master (output ADDR, output PAGE, input VALUE);
    modport slave  (input ADDR, input PAGE, output VALUE);

endinterface

// File: rtl/modulation_fetch_pipe.sv
// Delays each fetch tag by the BRAM read latency and captures the
// returned byte into the registered sample outputs.
module modulation_fetch_pipe
    import modulation_params_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  fetch_tag_t i_tag,
    input  logic [7:0] i_value,
    output logic [7:0] o_mod,
    output logic       o_valid,
    output mod_idx_t   o_idx,
    output logic       o_page
);

    // The incoming tag is already registered together with ADDR, so it
    // counts as the first latency stage.
    localparam int STAGES = READ_LATENCY - 1;

    fetch_tag_t r_tag [STAGES];
    fetch_tag_t w_tail;
    logic [7:0] r_mod;
    logic       r_valid;
    mod_idx_t   r_idx;
    logic       r_page;

    assign w_tail = r_tag[STAGES-1];

    // Shift the fetch tags toward the capture point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag stages are cleared on reset (unlike a data RAM)
            // because a surviving valid bit would emit a phantom sample.
            for (int i = 0; i < STAGES; i++) r_tag[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the
            // previous cycle's value, which is what makes this a shift.
            r_tag[0] <= i_tag;
            for (int i = 1; i < STAGES; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Capture VALUE when the tail tag matures; sample outputs hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mod   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_page  <= 1'b0;
        end else begin
            r_valid <= w_tail.valid;
            if (w_tail.valid) begin
                r_mod  <= i_value;
                r_idx  <= w_tail.idx;
                r_page <= w_tail.page;
            end
        end
    end

    assign o_mod   = r_mod;
    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_page  = r_page;

endmodule

// File: rtl/modulation_sampler.sv
// Steps through a modulation page on divided timer ticks, fetches each
// sample from BRAM and swaps pages only at loop boundaries.
module modulation_sampler
    import modulation_params_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  UPDATE_TICK,
    input  div_t                  FREQ_DIV,
    input  mod_idx_t              CYCLE_0,
    input  mod_idx_t              CYCLE_1,
    input  rep_t                  REPEAT,
    input  logic                  REQ_PAGE,
    modulation_sampler_if.master  bram,
    output logic [7:0]            MOD_OUT,
    output logic                  MOD_VALID,
    output mod_idx_t              IDX_OUT,
    output logic                  PAGE_OUT,
    output logic                  FINISHED
);

    state_t     r_state;
    mod_idx_t   r_idx;
    logic       r_page;
    div_t       r_div_cnt;
    rep_t       r_loop_cnt;
    logic       r_fetch;
    logic       r_finished;

    mod_idx_t   w_cyc;
    logic       w_step;
    logic       w_swap;
    fetch_tag_t w_tag;

    assign w_cyc  = r_page ? CYCLE_1 : CYCLE_0;
    assign w_swap = (REQ_PAGE != r_page);
    assign w_step = UPDATE_TICK && (r_div_cnt == div_last(FREQ_DIV));

    // Sequencer: divider, index stepping, loop counting and page swaps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_INIT;
            r_idx      <= '0;
            r_page     <= 1'b0;
            r_div_cnt  <= '0;
            r_loop_cnt <= '0;
            r_fetch    <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_fetch <= 1'b0;
            unique case (r_state)
                ST_INIT: begin
                    r_page     <= REQ_PAGE;
                    r_idx      <= '0;
                    r_div_cnt  <= '0;
                    r_loop_cnt <= '0;
                    r_fetch    <= 1'b1;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_step) begin
                        r_div_cnt <= '0;
                        if (r_idx < w_cyc) begin
                            r_idx   <= r_idx + mod_idx_t'(1);
                            r_fetch <= 1'b1;
                        end else if (w_swap) begin
                            // Pending page request lands exactly on the wrap.
                            r_page     <= REQ_PAGE;
                            r_idx      <= '0;
                            r_loop_cnt <= '0;
                            r_fetch    <= 1'b1;
                        end else if (REPEAT == REPEAT_INFINITE) begin
                            r_idx   <= '0;
                            r_fetch <= 1'b1;
                        end else if (r_loop_cnt == REPEAT) begin
                            // Last loop done: keep the final sample on screen.
                            r_finished <= 1'b1;
                            r_state    <= ST_FINISHED;
                        end else begin
                            r_loop_cnt <= r_loop_cnt + rep_t'(1);
                            r_idx      <= '0;
                            r_fetch    <= 1'b1;
                        end
                    end else if (UPDATE_TICK) begin
                        r_div_cnt <= r_div_cnt + div_t'(1);
                    end
                end
                ST_FINISHED: begin
                    if (w_swap) begin
                        r_page     <= REQ_PAGE;
                        r_idx      <= '0;
                        r_loop_cnt <= '0;
                        r_fetch    <= 1'b1;
                        r_finished <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bram.ADDR  = r_idx;
    assign bram.PAGE  = r_page;
    assign FINISHED   = r_finished;

    assign w_tag.valid = r_fetch;
    assign w_tag.idx   = r_idx;
    assign w_tag.page  = r_page;

    modulation_fetch_pipe u_fetch_pipe (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_tag   (w_tag),
        .i_value (bram.VALUE),
        .o_mod   (MOD_OUT),
        .o_valid (MOD_VALID),
        .o_idx   (IDX_OUT),
        .o_page  (PAGE_OUT)
    );

endmodule

// File: tb/tb_modulation_sampler.sv
// Self-checking bench: behavioural sample-sequence model plus a
// table of divider cases and directed multi-cycle corner sequences.
module tb_modulation_sampler;
    import modulation_params_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       UPDATE_TICK = 1'b0;
    logic       REQ_PAGE = 1'b0;
    div_t       FREQ_DIV = 16'd1;
    mod_idx_t   CYCLE_0 = 15'd7;
    mod_idx_t   CYCLE_1 = 15'd7;
    rep_t       REPEAT = 16'hFFFF;
    logic [7:0] MOD_OUT;
    logic       MOD_VALID;
    mod_idx_t   IDX_OUT;
    logic       PAGE_OUT;
    logic       FINISHED;

    modulation_sampler_if bus();

    modulation_sampler dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .UPDATE_TICK (UPDATE_TICK),
        .FREQ_DIV    (FREQ_DIV),
        .CYCLE_0     (CYCLE_0),
        .CYCLE_1     (CYCLE_1),
        .REPEAT      (REPEAT),
        .REQ_PAGE    (REQ_PAGE),
        .bram        (bus),
        .MOD_OUT     (MOD_OUT),
        .MOD_VALID   (MOD_VALID),
        .IDX_OUT     (IDX_OUT),
        .PAGE_OUT    (PAGE_OUT),
        .FINISHED    (FINISHED)
    );

    always #5 CLK = ~CLK;

    // Two-page BRAM: VALUE is the registered read of the address presented
    // on the previous cycle.
    logic [7:0] mem0 [0:32767];
    logic [7:0] mem1 [0:32767];
    always @(posedge CLK) bus.VALUE <= bus.PAGE ? mem1[bus.ADDR] : mem0[bus.ADDR];

    function automatic int mem_rd(input int page, input int idx);
        return (page != 0) ? int'(mem1[idx]) : int'(mem0[idx]);
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The model tracks which sample the sequence is on and predicts, per
    // emitted sample, the clock edge where it must appear on MOD_OUT.
    typedef struct { int due; int page; int idx; } exp_t;
    exp_t q[$];
    int m_phase;          // 0 start, 1 playing, 2 done
    int m_idx, m_page, m_ticks, m_loops, last_val;
    int n_edge = 0;
    int tick_period = 1;  // 0 selects random ticks
    bit seen_pulse;
    int seen_idx, seen_page;

    function automatic void emit(input int page, input int idx);
        exp_t e;
        e.due  = n_edge + 1 + READ_LATENCY;  // edge of fetch plus latency
        e.page = page;
        e.idx  = idx;
        q.push_back(e);
    endfunction

    function automatic void model_advance();
        int last;
        last = (m_page != 0) ? int'(CYCLE_1) : int'(CYCLE_0);
        if (m_idx < last) begin
            m_idx++;
            emit(m_page, m_idx);
        end else if (int'(REQ_PAGE) != m_page) begin
            m_page = int'(REQ_PAGE); m_idx = 0; m_loops = 0;
            emit(m_page, 0);
        end else if (REPEAT == 16'hFFFF) begin
            m_idx = 0;
            emit(m_page, 0);
        end else if (m_loops == int'(REPEAT)) begin
            m_phase = 2;
        end else begin
            m_loops++; m_idx = 0;
            emit(m_page, 0);
        end
    endfunction

    function automatic void model_edge(input bit tick);
        int lim;
        case (m_phase)
            0: begin
                m_page = int'(REQ_PAGE); m_idx = 0; m_ticks = 0; m_loops = 0;
                emit(m_page, 0);
                m_phase = 1;
            end
            1: if (tick) begin
                lim = (FREQ_DIV == 0) ? 1 : int'(FREQ_DIV);
                m_ticks++;
                if (m_ticks == lim) begin
                    m_ticks = 0;
                    model_advance();
                end
            end
            default: if (int'(REQ_PAGE) != m_page) begin
                m_page = int'(REQ_PAGE); m_idx = 0; m_loops = 0;
                emit(m_page, 0);
                m_phase = 1;
            end
        endcase
    endfunction

    task automatic model_check();
        bit due;
        exp_t e;
        due = (q.size() > 0) && (q[0].due == n_edge);
        check("mod_valid", MOD_VALID, due);
        if (due) begin
            e = q.pop_front();
            last_val = mem_rd(e.page, e.idx);
            check("idx_out", IDX_OUT, e.idx);
            check("page_out", PAGE_OUT, e.page);
            check("mod_out", MOD_OUT, last_val);
        end else begin
            check("mod_out_hold", MOD_OUT, last_val);
        end
        check("finished", FINISHED, m_phase == 2);
    endtask

    // One clock: drive tick, predict, clock, compare.
    task automatic step();
        bit t;
        if (tick_period == 0) t = 1'($urandom_range(0, 1));
        else                  t = ((n_edge % tick_period) == 0);
        UPDATE_TICK = t;
        model_edge(t);
        @(posedge CLK);
        n_edge++;
        #1;
        model_check();
        seen_pulse = MOD_VALID;
        seen_idx   = int'(IDX_OUT);
        seen_page  = int'(PAGE_OUT);
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!seen_pulse && k < budget);
        check({name, "_pulse_seen"}, seen_pulse, 1);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        #1;
        check("rst_mod_out", MOD_OUT, 0);
        check("rst_mod_valid", MOD_VALID, 0);
        check("rst_idx_out", IDX_OUT, 0);
        check("rst_page_out", PAGE_OUT, 0);
        check("rst_finished", FINISHED, 0);
        check("rst_addr", bus.ADDR, 0);
        check("rst_page", bus.PAGE, 0);
        q.delete();
        m_phase = 0; m_idx = 0; m_page = 0; m_ticks = 0; m_loops = 0; last_val = 0;
        repeat (2) begin
            @(posedge CLK);
            n_edge++;
        end
        #1 RST_N = 1'b1;
    endtask

    // Divider cases: steady-state spacing between MOD_VALID pulses.
    typedef struct { div_t freq_div; int period; int interval; } div_vec_t;

    initial begin
        div_vec_t vecs [6];
        int sw_idx [4];
        int sw_pg  [4];
        int init_edge, e2, e3, k, cnt;

        vecs[0] = '{16'd1, 1, 1};
        vecs[1] = '{16'd0, 1, 1};
        vecs[2] = '{16'd4, 3, 12};
        vecs[3] = '{16'd0, 3, 3};
        vecs[4] = '{16'd2, 1, 2};
        vecs[5] = '{16'd3, 2, 6};
        sw_idx = '{5, 6, 7, 0};
        sw_pg  = '{0, 0, 0, 1};

        for (int i = 0; i < 32768; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end
        #2;

        // ---- basic stepping and first-sample latency ----
        FREQ_DIV = 16'd1; CYCLE_0 = 15'd7; REPEAT = 16'hFFFF; REQ_PAGE = 1'b0; tick_period = 1;
        apply_reset();
        init_edge = n_edge + 1;
        wait_pulse("first", 10);
        check("first_latency", n_edge - init_edge, READ_LATENCY);
        check("first_idx", seen_idx, 0);
        for (int i = 1; i < 18; i++) begin
            wait_pulse("basic", 5);
            check("basic_idx", seen_idx, i % 8);
            check("basic_val", MOD_OUT, mem0[i % 8]);
        end

        // ---- divider table ----
        for (int v = 0; v < 6; v++) begin
            FREQ_DIV = vecs[v].freq_div;
            tick_period = vecs[v].period;
            apply_reset();
            wait_pulse("div_a", 100);
            wait_pulse("div_b", 100);
            wait_pulse("div_c", 100);
            e2 = n_edge;
            wait_pulse("div_d", 100);
            e3 = n_edge;
            check("div_interval", e3 - e2, vecs[v].interval);
        end

        // ---- seamless swap at wrap ----
        FREQ_DIV = 16'd1; tick_period = 1; CYCLE_0 = 15'd7; CYCLE_1 = 15'd7; REQ_PAGE = 1'b0;
        apply_reset();
        k = 0;
        do begin step(); k++; end while (bus.ADDR != 15'd3 && k < 50);
        check("swap_addr3", bus.ADDR, 3);
        REQ_PAGE = 1'b1;
        k = 0;
        do begin wait_pulse("swap_pre", 20); k++; end while (!(seen_page == 0 && seen_idx == 4) && k < 6);
        check("swap_start_idx", seen_idx, 4);
        check("swap_start_page", seen_page, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("swap_seq_valid", seen_pulse, 1);
            check("swap_seq_idx", seen_idx, sw_idx[i]);
            check("swap_seq_page", seen_page, sw_pg[i]);
        end

        // ---- finite loops, hold, restart ----
        REQ_PAGE = 1'b0; CYCLE_0 = 15'd3; REPEAT = 16'd2;
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(seen_pulse);
        end
        check("finite_count", cnt, 12);
        check("finite_flag", FINISHED, 1);
        check("finite_hold", MOD_OUT, mem0[3]);
        REQ_PAGE = 1'b1;
        wait_pulse("restart", 10);
        check("restart_idx", seen_idx, 0);
        check("restart_page", seen_page, 1);
        check("restart_flag", FINISHED, 0);

        // ---- full-depth page wraps to 0 ----
        REPEAT = 16'hFFFF; CYCLE_1 = 15'd32767; REQ_PAGE = 1'b1;
        apply_reset();
        k = 0;
        do begin step(); k++; end while (!(seen_pulse && seen_idx == 32767) && k < 33000);
        check("max_reached", seen_idx, 32767);
        step();
        check("max_wrap_valid", seen_pulse, 1);
        check("max_wrap_idx", seen_idx, 0);
        check("max_wrap_page", seen_page, 1);

        // ---- live CYCLE_0 lowered below current index ----
        REQ_PAGE = 1'b0; CYCLE_0 = 15'd7;
        apply_reset();
        k = 0;
        do begin step(); k++; end while (bus.ADDR != 15'd5 && k < 50);
        check("lower_addr5", bus.ADDR, 5);
        CYCLE_0 = 15'd2;
        k = 0;
        do begin wait_pulse("lower_pre", 20); k++; end while (seen_idx != 5 && k < 5);
        check("lower_at5", seen_idx, 5);
        step();
        check("lower_wrap_valid", seen_pulse, 1);
        check("lower_wrap_idx", seen_idx, 0);

        // ---- reset with fetches in flight ----
        CYCLE_0 = 15'd7;
        wait_pulse("midrun", 10);
        wait_pulse("midrun2", 10);
        apply_reset();
        wait_pulse("after_rst", 10);
        check("after_rst_idx", seen_idx, 0);
        check("after_rst_page", seen_page, 0);

        // ---- randomized runs against the model ----
        for (int r = 0; r < 6; r++) begin
            CYCLE_0  = 15'($urandom_range(0, 9));
            CYCLE_1  = 15'($urandom_range(0, 9));
            FREQ_DIV = 16'($urandom_range(0, 3));
            REPEAT   = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2));
            REQ_PAGE = 1'($urandom_range(0, 1));
            tick_period = 0;
            apply_reset();
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 39) == 0) REQ_PAGE = ~REQ_PAGE;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modulation_sampler.md
Name: modulation_sampler

Overview:
- Read-side initiator of the modulation BRAM bus. It is the consumer end of the ADDR/PAGE -> VALUE port that the memory block serves from the two modulation pages.
- It steps a sample index on a timer tick and a frequency divider, and fetches each sample with the fixed 2-cycle read latency.
- It presents each intensity-modulation byte to the downstream duty/intensity pipeline.
- Page swaps happen only at loop boundaries (seamless double-buffering).
- It supports finite loop counts, holding the last sample when finished.

Parameters:
- DEPTH_BITS, 15, address width; one page holds 2^DEPTH_BITS samples.
- READ_LATENCY, 2, cycles from ADDR/PAGE presented to VALUE valid.
- DIV_BITS, 16, width of FREQ_DIV.
- REP_BITS, 16, width of REPEAT; all-ones means infinite.

Ports:
- CLK  in  1  system clock (20.48 MHz domain)
- RST_N  in  1  asynchronous active-low reset
- UPDATE_TICK  in  1  one-cycle sampling-tick pulse from the system-time block
- FREQ_DIV  in  DIV_BITS  ticks per sample step; 0 is treated as 1
- CYCLE_0  in  DEPTH_BITS  last valid index of page 0
- CYCLE_1  in  DEPTH_BITS  last valid index of page 1
- REPEAT  in  REP_BITS  extra loops after the first; all-ones means infinite
- REQ_PAGE  in  1  page requested by CPU-side control
- ADDR  out  DEPTH_BITS  BRAM read address
- PAGE  out  1  BRAM read page
- VALUE  in  8  BRAM read data, valid READ_LATENCY cycles after ADDR/PAGE
- MOD_OUT  out  8  current modulation sample
- MOD_VALID  out  1  one-cycle pulse when MOD_OUT updates
- IDX_OUT  out  DEPTH_BITS  index of the sample in MOD_OUT
- PAGE_OUT  out  1  page of the sample in MOD_OUT
- FINISHED  out  1  high while holding after the loops are exhausted

Behaviour:
- Reset (async assert, sync release):
  - ADDR=0, PAGE=0, MOD_OUT=0, MOD_VALID=0, IDX_OUT=0, PAGE_OUT=0, FINISHED=0.
  - Internal idx, div_cnt and loop_cnt are cleared; the state is INIT.
- FSM states: INIT, RUN, FINISHED.
- INIT:
  - Lasts one cycle. It latches PAGE<=REQ_PAGE, drives ADDR=0 and issues a fetch, then moves to RUN.
  - The first MOD_VALID occurs READ_LATENCY cycles after the INIT cycle.
- Divider (RUN only):
  - On UPDATE_TICK, div_cnt increments.
  - When div_cnt == max(FREQ_DIV,1)-1 on a tick, div_cnt<=0 and a step occurs.
  - Without a tick, div_cnt holds.
- Step:
  - cyc = (PAGE ? CYCLE_1 : CYCLE_0).
  - If idx < cyc: idx<=idx+1.
  - Otherwise (wrap, including idx > cyc after a live CYCLE change): idx<=0.
- Wrap handling:
  - If REQ_PAGE != PAGE: PAGE<=REQ_PAGE and loop_cnt<=0. A swap always restarts the loop count.
  - Else if REPEAT is all-ones: loop_cnt holds.
  - Else if loop_cnt == REPEAT: idx stays at cyc, no fetch is issued, and the state moves to FINISHED.
  - Else: loop_cnt<=loop_cnt+1.
- Fetch: every step that changes idx or PAGE drives ADDR/PAGE in the same cycle the register updates (registered outputs). At most one fetch is issued per cycle.
- Latency pipeline:
  - A READ_LATENCY-deep shift register carries {valid, idx, page} alongside each fetch.
  - When the tail entry is valid: MOD_OUT<=VALUE, IDX_OUT<=idx, PAGE_OUT<=page, MOD_VALID<=1 for exactly one cycle.
  - MOD_OUT holds between updates.
- FINISHED state:
  - FINISHED=1; ADDR, PAGE and MOD_OUT hold.
  - If REQ_PAGE != PAGE: PAGE<=REQ_PAGE, idx<=0, loop_cnt<=0, fetch issued, FINISHED<=0, state moves to RUN.
  - Ticks are ignored.
- Simultaneous events:
  - A tick-driven wrap and a REQ_PAGE change in the same cycle: the swap applies at that wrap.
  - A REQ_PAGE change not at a wrap is deferred until the next wrap.
- Width rules:
  - Index arithmetic is modulo 2^DEPTH_BITS. CYCLE = 2^DEPTH_BITS-1 wraps naturally to 0.
  - loop_cnt is REP_BITS wide, compared for equality only.
- Reset mid-operation: all in-flight pipeline entries are discarded; no MOD_VALID is issued for them.

Decomposition:
- Shared package (modulation_params_pkg):
  - Constants: DEPTH_BITS, READ_LATENCY, REPEAT_INFINITE (all-ones).
  - Typedefs: mod_idx_t (logic [DEPTH_BITS-1:0]), state enum {INIT, RUN, FINISHED}.
- One natural sub-module: modulation_fetch_pipe. It holds the parameterised READ_LATENCY tag shift register plus the capture of VALUE into MOD_OUT/IDX_OUT/PAGE_OUT/MOD_VALID.

Test Plan:
- Basic stepping: page 0 random bytes, CYCLE_0=7, FREQ_DIV=1, REPEAT=all-ones, tick every cycle -> IDX_OUT runs 0..7,0.., MOD_OUT == buf0[IDX_OUT] every pulse, first MOD_VALID 2 cycles after INIT.
- Divider: FREQ_DIV=4, tick every 3rd cycle -> MOD_VALID every 12 cycles. FREQ_DIV=0 behaves identically to FREQ_DIV=1.
- Seamless swap: REQ_PAGE 0->1 raised at idx=3, CYCLE_0=7 -> page-0 samples 4..7 emitted, then page-1 idx 0 with no gap or duplicate.
- Finite loops: REPEAT=2, CYCLE_0=3 -> exactly 12 MOD_VALID pulses, then FINISHED=1 with MOD_OUT=buf0[3] held. A later REQ_PAGE toggle restarts from page-1 idx 0.
- Boundaries: CYCLE_1=32767 wraps to 0; CYCLE_0 lowered from 7 to 2 while idx=5 -> next step wraps to 0.
- Reset mid-run: RST_N low with fetches in flight -> outputs 0 asynchronously, no stray MOD_VALID after release; the restart fetches idx 0.
